regfile_wb_sched: RTL and testbench

Write-back scheduler for the 32x32 register file. It accepts write requests from the ALU, data-memory load, and PC-link (jump-and-link) producers, grants one per cycle, and drives the register file's write controls from a registered output stage. It also keeps a per-register pending-write scoreboard that decode uses to stall on read-after-write hazards.

---
 rtl/regfile_wb_sched.sv | 148 ++++++++++++++
 tb/tb_regfile_wb_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the 32x32 register file: arbitrates ALU/MEM/PC writes into a
// registered write stage and tracks pending writes per register. Define WB_RR_EN for round-robin.
module regfile_wb_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic        mem_valid,
    input  logic        pc_valid,
    output logic        alu_ready,
    output logic        mem_ready,
    output logic        pc_ready,
    input  logic [4:0]  alu_dest,
    input  logic [4:0]  mem_dest,
    input  logic [4:0]  pc_dest,
    input  logic [31:0] alu_data,
    input  logic [31:0] mem_data,
    input  logic [31:0] pc_data,
    output logic        rf_alu_in,
    output logic        rf_memrd,
    output logic        rf_pc_in,
    output logic [4:0]  rf_sel_dest,
    output logic [31:0] rf_alu_data,
    output logic [31:0] rf_mem_data,
    output logic [31:0] rf_pc_data,
    input  logic        sb_set,
    input  logic [4:0]  sb_set_reg,
    input  logic [4:0]  sb_q1,
    input  logic [4:0]  sb_q2,
    output logic        sb_busy1,
    output logic        sb_busy2,
    output logic        sb_full
);
    localparam int unsigned NREQ = 3;

    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic [4:0]      acc_dest;
    logic [31:0]     pend;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;

    // Nothing is granted while reset is held; requesters re-arbitrate once it drops.
    assign req_valid = {pc_valid, mem_valid, alu_valid} & {NREQ{~rst}};

`ifdef WB_RR_EN
    typedef enum logic [1:0] {
        PTR_ALU = 2'd0,
        PTR_MEM = 2'd1,
        PTR_PC  = 2'd2
    } ptr_t;

    ptr_t ptr;
    ptr_t ptr_next;

    always_comb begin
        grant = '0;
        unique case (ptr)
            PTR_MEM: begin
                if (req_valid[1])      grant = 3'b010;
                else if (req_valid[2]) grant = 3'b100;
                else if (req_valid[0]) grant = 3'b001;
            end
            PTR_PC: begin
                if (req_valid[2])      grant = 3'b100;
                else if (req_valid[0]) grant = 3'b001;
                else if (req_valid[1]) grant = 3'b010;
            end
            default: begin
                if (req_valid[0])      grant = 3'b001;
                else if (req_valid[1]) grant = 3'b010;
                else if (req_valid[2]) grant = 3'b100;
            end
        endcase
    end

    always_comb begin
        ptr_next = ptr;
        if (grant[0])      ptr_next = PTR_MEM;
        else if (grant[1]) ptr_next = PTR_PC;
        else if (grant[2]) ptr_next = PTR_ALU;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= PTR_ALU;
        else     ptr <= ptr_next;
    end
`else
    always_comb begin
        grant = '0;
        if (req_valid[0])      grant = 3'b001;
        else if (req_valid[1]) grant = 3'b010;
        else if (req_valid[2]) grant = 3'b100;
    end
`endif

    assign alu_ready = grant[0];
    assign mem_ready = grant[1];
    assign pc_ready  = grant[2];
    assign accept    = |grant;

    always_comb begin
        acc_dest = '0;
        if (grant[0])      acc_dest = alu_dest;
        else if (grant[1]) acc_dest = mem_dest;
        else if (grant[2]) acc_dest = pc_dest;
    end

    // Selects are recomputed every cycle so an idle cycle never repeats the last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_alu_in   <= 1'b0;
            rf_memrd    <= 1'b0;
            rf_pc_in    <= 1'b0;
            rf_sel_dest <= '0;
            rf_alu_data <= '0;
            rf_mem_data <= '0;
            rf_pc_data  <= '0;
        end else begin
            rf_alu_in <= grant[0] && (alu_dest != 5'd0);
            rf_memrd  <= grant[1] && (mem_dest != 5'd0);
            rf_pc_in  <= grant[2] && (pc_dest  != 5'd0);
            if (accept)   rf_sel_dest <= acc_dest;
            if (grant[0]) rf_alu_data <= alu_data;
            if (grant[1]) rf_mem_data <= mem_data;
            if (grant[2]) rf_pc_data  <= pc_data;
        end
    end

    // Set is applied after clear so a same-edge set/clear of one register leaves it pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (sb_set) set_mask[sb_set_reg] = 1'b1;
        if (accept) clr_mask[acc_dest]   = 1'b1;
        set_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else     pend <= ((pend & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end

    assign sb_busy1 = pend[sb_q1];
    assign sb_busy2 = pend[sb_q2];
    assign sb_full  = &pend[31:1];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: vector table for single transfers plus hand sequences
// for contention, scoreboard hazards and asynchronous reset; follows WB_RR_EN when defined.
module tb_regfile_wb_sched;
    logic        clk;
    logic        rst;
    logic        alu_valid, mem_valid, pc_valid;
    logic        alu_ready, mem_ready, pc_ready;
    logic [4:0]  alu_dest, mem_dest, pc_dest;
    logic [31:0] alu_data, mem_data, pc_data;
    logic        rf_alu_in, rf_memrd, rf_pc_in;
    logic [4:0]  rf_sel_dest;
    logic [31:0] rf_alu_data, rf_mem_data, rf_pc_data;
    logic        sb_set;
    logic [4:0]  sb_set_reg, sb_q1, sb_q2;
    logic        sb_busy1, sb_busy2, sb_full;

    int checks;
    int failures;

    regfile_wb_sched dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .mem_valid(mem_valid), .pc_valid(pc_valid),
        .alu_ready(alu_ready), .mem_ready(mem_ready), .pc_ready(pc_ready),
        .alu_dest(alu_dest), .mem_dest(mem_dest), .pc_dest(pc_dest),
        .alu_data(alu_data), .mem_data(mem_data), .pc_data(pc_data),
        .rf_alu_in(rf_alu_in), .rf_memrd(rf_memrd), .rf_pc_in(rf_pc_in),
        .rf_sel_dest(rf_sel_dest),
        .rf_alu_data(rf_alu_data), .rf_mem_data(rf_mem_data), .rf_pc_data(rf_pc_data),
        .sb_set(sb_set), .sb_set_reg(sb_set_reg), .sb_q1(sb_q1), .sb_q2(sb_q2),
        .sb_busy1(sb_busy1), .sb_busy2(sb_busy2), .sb_full(sb_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  v;
        logic [4:0]  ad, md, pd;
        logic [31:0] adat, mdat, pdat;
        logic [2:0]  exp_rdy;
        logic [2:0]  exp_sel;
        logic [4:0]  exp_dest;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [2:0] v, input logic [4:0] ad, input logic [4:0] md,
                                input logic [4:0] pd, input logic [31:0] adat,
                                input logic [31:0] mdat, input logic [31:0] pdat,
                                input logic [2:0] er, input logic [2:0] es,
                                input logic [4:0] ed, input logic [31:0] edat);
        vec_t r;
        r.v = v; r.ad = ad; r.md = md; r.pd = pd;
        r.adat = adat; r.mdat = mdat; r.pdat = pdat;
        r.exp_rdy = er; r.exp_sel = es; r.exp_dest = ed; r.exp_data = edat;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; mem_valid = 1'b0; pc_valid = 1'b0;
        alu_dest = '0; mem_dest = '0; pc_dest = '0;
        alu_data = '0; mem_data = '0; pc_data = '0;
        sb_set = 1'b0; sb_set_reg = '0; sb_q1 = '0; sb_q2 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    function automatic logic [31:0] lane(input logic [2:0] s);
        case (s)
            3'b010:  return rf_mem_data;
            3'b100:  return rf_pc_data;
            default: return rf_alu_data;
        endcase
    endfunction

    function automatic logic [2:0] contention_exp(input int c);
        logic [2:0] e;
        e = 3'b001;
`ifdef WB_RR_EN
        e = e << (c % 3);
`endif
        return e;
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        idle_inputs();

        // Reset state, with requests already valid during reset.
        rst = 1'b1;
        alu_valid = 1'b1; mem_valid = 1'b1; pc_valid = 1'b1;
        alu_dest = 5'd1; mem_dest = 5'd2; pc_dest = 5'd3;
        #1;
        chk("reset_ready", {29'd0, pc_ready, mem_ready, alu_ready}, 32'd0);
        chk("reset_sel", {29'd0, rf_pc_in, rf_memrd, rf_alu_in}, 32'd0);
        chk("reset_dest", {27'd0, rf_sel_dest}, 32'd0);
        chk("reset_alu_data", rf_alu_data, 32'd0);
        chk("reset_mem_data", rf_mem_data, 32'd0);
        chk("reset_pc_data", rf_pc_data, 32'd0);
        chk("reset_full", {31'd0, sb_full}, 32'd0);
        step();
        chk("reset_hold_ready", {29'd0, pc_ready, mem_ready, alu_ready}, 32'd0);
        chk("reset_hold_sel", {29'd0, rf_pc_in, rf_memrd, rf_alu_in}, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single-requester transfers and idle cycles.
        vecs[0] = mk(3'b001, 5'd5,  5'd0,  5'd0,  32'hDEADBEEF, 32'h0, 32'h0,
                     3'b001, 3'b001, 5'd5, 32'hDEADBEEF);
        vecs[1] = mk(3'b000, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0,
                     3'b000, 3'b000, 5'd0, 32'h0);
        vecs[2] = mk(3'b010, 5'd0,  5'd12, 5'd0,  32'h0, 32'hA5A50001, 32'h0,
                     3'b010, 3'b010, 5'd12, 32'hA5A50001);
        vecs[3] = mk(3'b100, 5'd0,  5'd0,  5'd31, 32'h0, 32'h0, 32'h00000400,
                     3'b100, 3'b100, 5'd31, 32'h00000400);
        vecs[4] = mk(3'b100, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h00001234,
                     3'b100, 3'b000, 5'd0, 32'h0);
        vecs[5] = mk(3'b001, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFF, 32'h0, 32'h0,
                     3'b001, 3'b001, 5'd1, 32'hFFFFFFFF);
        vecs[6] = mk(3'b010, 5'd0,  5'd30, 5'd0,  32'h0, 32'h13579BDF, 32'h0,
                     3'b010, 3'b010, 5'd30, 32'h13579BDF);
        vecs[7] = mk(3'b000, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0,
                     3'b000, 3'b000, 5'd0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            alu_valid = vecs[i].v[0]; mem_valid = vecs[i].v[1]; pc_valid = vecs[i].v[2];
            alu_dest = vecs[i].ad; mem_dest = vecs[i].md; pc_dest = vecs[i].pd;
            alu_data = vecs[i].adat; mem_data = vecs[i].mdat; pc_data = vecs[i].pdat;
            #1;
            chk($sformatf("vec%0d_ready", i), {29'd0, pc_ready, mem_ready, alu_ready},
                {29'd0, vecs[i].exp_rdy});
            step();
            chk($sformatf("vec%0d_sel", i), {29'd0, rf_pc_in, rf_memrd, rf_alu_in},
                {29'd0, vecs[i].exp_sel});
            if (vecs[i].exp_sel != 3'b000) begin
                chk($sformatf("vec%0d_dest", i), {27'd0, rf_sel_dest}, {27'd0, vecs[i].exp_dest});
                chk($sformatf("vec%0d_data", i), lane(vecs[i].exp_sel), vecs[i].exp_data);
            end
        end

        // Continuous contention from all three requesters.
        do_reset();
        alu_valid = 1'b1; mem_valid = 1'b1; pc_valid = 1'b1;
        alu_dest = 5'd1; mem_dest = 5'd2; pc_dest = 5'd3;
        alu_data = 32'h11111111; mem_data = 32'h22222222; pc_data = 32'h33333333;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("contend%0d_ready", c), {29'd0, pc_ready, mem_ready, alu_ready},
                {29'd0, contention_exp(c)});
            step();
            chk($sformatf("contend%0d_sel", c), {29'd0, rf_pc_in, rf_memrd, rf_alu_in},
                {29'd0, contention_exp(c)});
        end
        idle_inputs();
        step();

        // Scoreboard: set reg 7, cleared by a MEM write accepted four cycles later.
        sb_set = 1'b1; sb_set_reg = 5'd7; sb_q1 = 5'd7;
        #1;
        chk("sb7_c0_busy", {31'd0, sb_busy1}, 32'd0);
        step();
        sb_set = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("sb7_c%0d_busy", c), {31'd0, sb_busy1}, 32'd1);
            step();
        end
        mem_valid = 1'b1; mem_dest = 5'd7; mem_data = 32'h0BADF00D;
        #1;
        chk("sb7_c4_ready", {31'd0, mem_ready}, 32'd1);
        chk("sb7_c4_busy", {31'd0, sb_busy1}, 32'd1);
        step();
        mem_valid = 1'b0;
        chk("sb7_c5_busy", {31'd0, sb_busy1}, 32'd0);
        chk("sb7_c5_memrd", {31'd0, rf_memrd}, 32'd1);
        chk("sb7_c5_dest", {27'd0, rf_sel_dest}, 32'd7);

        // Same-edge set and clear of reg 9: set wins.
        sb_set = 1'b1; sb_set_reg = 5'd9; sb_q2 = 5'd9;
        alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h99999999;
        #1;
        chk("sb9_ready", {31'd0, alu_ready}, 32'd1);
        step();
        sb_set = 1'b0; alu_valid = 1'b0;
        chk("sb9_busy", {31'd0, sb_busy2}, 32'd1);
        chk("sb9_alu_in", {31'd0, rf_alu_in}, 32'd1);
        alu_valid = 1'b1;
        step();
        alu_valid = 1'b0;
        chk("sb9_cleared", {31'd0, sb_busy2}, 32'd0);

        // Register 0: never tracked, never written.
        sb_set = 1'b1; sb_set_reg = 5'd0; sb_q1 = 5'd0;
        pc_valid = 1'b1; pc_dest = 5'd0; pc_data = 32'h00001234;
        #1;
        chk("r0_pc_ready", {31'd0, pc_ready}, 32'd1);
        step();
        sb_set = 1'b0; pc_valid = 1'b0;
        chk("r0_busy", {31'd0, sb_busy1}, 32'd0);
        chk("r0_sel", {29'd0, rf_pc_in, rf_memrd, rf_alu_in}, 32'd0);

        // Fill the scoreboard one register per cycle.
        for (int r = 1; r <= 31; r++) begin
            sb_set = 1'b1; sb_set_reg = 5'(r);
            step();
            if (r == 30) chk("full_at30", {31'd0, sb_full}, 32'd0);
        end
        sb_set = 1'b0;
        chk("full_at31", {31'd0, sb_full}, 32'd1);

        // Asynchronous reset while a select is high.
        alu_valid = 1'b1; alu_dest = 5'd4; alu_data = 32'hCAFEF00D;
        step();
        chk("midrst_pre_sel", {31'd0, rf_alu_in}, 32'd1);
        alu_dest = 5'd1; mem_valid = 1'b1; mem_dest = 5'd2; pc_valid = 1'b1; pc_dest = 5'd3;
        sb_q1 = 5'd31;
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_sel", {29'd0, rf_pc_in, rf_memrd, rf_alu_in}, 32'd0);
        chk("midrst_dest", {27'd0, rf_sel_dest}, 32'd0);
        chk("midrst_alu_data", rf_alu_data, 32'd0);
        chk("midrst_full", {31'd0, sb_full}, 32'd0);
        chk("midrst_busy31", {31'd0, sb_busy1}, 32'd0);
        chk("midrst_ready", {29'd0, pc_ready, mem_ready, alu_ready}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("postrst_ready", {29'd0, pc_ready, mem_ready, alu_ready}, 32'd1);
        step();
        chk("postrst_sel", {29'd0, rf_pc_in, rf_memrd, rf_alu_in}, 32'd1);
        chk("postrst_dest", {27'd0, rf_sel_dest}, 32'd1);
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
